// File: rtl/corr_pkg.sv
// Shared constants and types for the sine-correlator front end.
// Contents:
//   N_TAPS, SAMPLE_W, TIM_W  frame length and datapath widths
//   IDLE_TIM                 tim code held between frames (outside 0..N_TAPS-1)
//   sample_t, tim_t, ptr_t   signed sample, phase index, frame pointer
//   rd_state_e               playback FSM states
package corr_pkg;

    localparam int N_TAPS   = 20;
    localparam int SAMPLE_W = 8;
    localparam int TIM_W    = 5;
    localparam int PTR_W    = $clog2(N_TAPS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [TIM_W-1:0]    tim_t;
    typedef logic        [PTR_W-1:0]    ptr_t;

    localparam tim_t IDLE_TIM = tim_t'(31);
    localparam ptr_t PTR_LAST = ptr_t'(N_TAPS - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } rd_state_e;

endpackage

// File: rtl/pingpong_bank.sv
// Two-bank frame store, N_TAPS samples per bank.
// Ports:
//   clk                         write clock
//   we, wr_bank, wr_ptr, wr_data  synchronous write port
//   rd_bank, rd_ptr             read address
//   rd_data                     combinational read data
// Storage is not reset; full flags that qualify the contents live in the parent.
module pingpong_bank
    import corr_pkg::*;
(
    input  logic    clk,
    input  logic    we,
    input  logic    wr_bank,
    input  ptr_t    wr_ptr,
    input  sample_t wr_data,
    input  logic    rd_bank,
    input  ptr_t    rd_ptr,
    output sample_t rd_data
);

    sample_t mem_q [2][N_TAPS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_bank][wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_bank][rd_ptr];

endmodule

// File: rtl/corr_frame_feeder.sv
// Collects a valid/ready sample stream into 20-sample frames (ping-pong
// buffered) and replays each complete frame to the correlator, one sample per
// cycle, with tim counting the phase.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous flush of all frames and playback
//   in_valid/in_ready upstream handshake, in_sample signed data
//   tim, sel_sig      registered phase index and aligned sample
//   busy              high while tim is a real phase (0..N_TAPS-1)
//   frame_cnt         frames fully played out, wraps
module corr_frame_feeder
    import corr_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    input  sample_t      in_sample,
    output logic         in_ready,
    output tim_t         tim,
    output sample_t      sel_sig,
    output logic         busy,
    output logic [7:0]   frame_cnt
);

    rd_state_e  state_q, state_d;
    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    logic       rd_bank_q, rd_bank_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    tim_t       tim_q, tim_d;
    sample_t    sel_q, sel_d;
    logic       busy_q, busy_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    logic    accept;
    sample_t rd_data;

    // The written bank can only be full when both banks hold frames.
    assign in_ready = ~full_q[wr_bank_q];
    assign accept   = in_valid & in_ready & ~clr;

    // Read address is the next-cycle playback position, so the sample lands
    // in sel_q on the same edge as its phase lands in tim_q.
    pingpong_bank u_bank (
        .clk     (clk),
        .we      (accept),
        .wr_bank (wr_bank_q),
        .wr_ptr  (wr_ptr_q),
        .wr_data (in_sample),
        .rd_bank (rd_bank_d),
        .rd_ptr  (rd_ptr_d),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_ptr_d    = wr_ptr_q;
        rd_bank_d   = rd_bank_q;
        rd_ptr_d    = rd_ptr_q;
        frame_cnt_d = frame_cnt_q;
        busy_d      = 1'b0;

        // Write side
        if (accept) begin
            if (wr_ptr_q == PTR_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_ptr_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
        end

        // Read side. The bank being freed is never the bank being completed
        // (a write needs its bank empty, a free needs it full), so both flag
        // updates can be applied without ordering concerns.
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = PLAY;
                    rd_ptr_d = '0;
                    busy_d   = 1'b1;
                end
            end
            PLAY: begin
                if (rd_ptr_q != PTR_LAST) begin
                    rd_ptr_d = rd_ptr_q + ptr_t'(1);
                    busy_d   = 1'b1;
                end else begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    rd_ptr_d          = '0;
                    frame_cnt_d       = frame_cnt_q + 8'd1;
                    // Other bank already complete: start it with no gap.
                    if (full_q[~rd_bank_q]) begin
                        busy_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything; the aborted frame is not counted.
        if (clr) begin
            state_d     = IDLE;
            full_d      = '0;
            wr_bank_d   = 1'b0;
            wr_ptr_d    = '0;
            rd_bank_d   = 1'b0;
            rd_ptr_d    = '0;
            frame_cnt_d = frame_cnt_q;
            busy_d      = 1'b0;
        end
    end

    assign tim_d = busy_d ? tim_t'(rd_ptr_d) : IDLE_TIM;
    assign sel_d = busy_d ? rd_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_ptr_q    <= '0;
            tim_q       <= IDLE_TIM;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_bank_q   <= rd_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            tim_q       <= tim_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tim       = tim_q;
    assign sel_sig   = sel_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule
